sort8_frame_loader: RTL and testbench
=====================================

Name: sort8_frame_loader

Overview:
- Upstream stage of the 8-input byte sorter (ordena8).
- Accepts a serial byte stream over a valid/ready handshake and packs up to 8 bytes into one frame.
- Pads short frames and presents the frame in parallel on a1..h1, held stable under a frame_valid/frame_ready handshake while the combinational sorter consumes it.

Parameters:
- WIDTH, 8, bit width of each element. The sorter requires 8.
- PAD_VALUE, 8'hFF, value written to unfilled slots of a short frame so that pads sort to the top.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  upstream byte valid
s_ready  output  1  loader can accept a byte
s_data  input  WIDTH  upstream byte
s_last  input  1  byte is the final one of its frame; qualified by s_valid
a1  output  WIDTH  slot 0, first byte received
b1  output  WIDTH  slot 1
c1  output  WIDTH  slot 2
d1  output  WIDTH  slot 3
e1  output  WIDTH  slot 4
f1  output  WIDTH  slot 5
g1  output  WIDTH  slot 6
h1  output  WIDTH  slot 7, eighth byte received
frame_valid  output  1  a1..h1 hold a complete frame
frame_ready  input  1  downstream has consumed the frame
frame_count  output  4  number of real bytes in the held frame, 1..8
frames_sent  output  16  count of frames released downstream

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = FILL; fill index = 0.
  - a1..h1 = 0, frame_valid = 0, frame_count = 0, frames_sent = 0.
  - Asserting reset mid-frame or mid-hold discards all data.
- Transfer: a byte transfers on a rising edge when s_valid && s_ready.
- s_ready is combinational: s_ready = (state == FILL). It never depends on s_valid.
- State FILL:
  - Each transfer writes s_data into slot[index] and increments index.
  - The frame closes on the transfer where index == 7 or s_last == 1. s_last on byte 8 equals an implicit close.
  - On the closing edge:
    - Slots index+1..7 are loaded with PAD_VALUE in the same cycle.
    - frame_count = index+1.
    - State moves to HOLD, and frame_valid = 1 from the next cycle.
    - index resets to 0.
- State HOLD:
  - s_ready = 0. a1..h1 and frame_count are stable.
  - frame_valid stays 1 until frame_valid && frame_ready is sampled on an edge.
  - On that edge:
    - State moves to FILL and frame_valid goes 0 next cycle.
    - frames_sent increments, wrapping 0xFFFF -> 0x0000.
    - Slots retain old values until overwritten.
- frame_ready while frame_valid = 0 has no effect.
- s_valid while in HOLD: no transfer occurs. Upstream must hold the byte, per standard valid/ready rules.
- A 9th consecutive byte without s_last starts a new frame after the HOLD of the previous frame is released.
- Latency:
  - frame_valid rises 1 cycle after the closing transfer.
  - s_ready rises 1 cycle after release (combinational from state).
  - Peak throughput: one full frame per 9 cycles with frame_ready tied high.
- All outputs are registered except s_ready.

Test Plan:
- Reset, then 8 bytes 0x10,0x20,...,0x80 with s_valid held high and frame_ready=0 -> s_ready drops after the 8th byte; next cycle frame_valid=1, a1=0x10..h1=0x80, frame_count=8; outputs stable for 5 held cycles.
- Short frame 0x05,0x03,0x09 with s_last on 0x09 -> frame_valid=1, a1=0x05, b1=0x03, c1=0x09, d1..h1=0xFF, frame_count=3.
- In HOLD, drive s_valid=1, s_data=0xAA for 4 cycles, then pulse frame_ready for one cycle -> no transfer during HOLD; frames_sent increments by 1; 0xAA lands in a1 of the next frame.
- frame_ready tied high, 3 back-to-back 8-byte frames -> frame_valid pulses once per 9 cycles; frames_sent = 3; no byte lost or duplicated.
- rst_n asserted asynchronously after 4 bytes, mid-cycle -> immediately a1..h1=0, frame_valid=0, frames_sent=0; after release s_ready=1 and the next byte lands in a1.
- Preload frames_sent to 0xFFFF by running 65535 frames (or via force), release one more frame -> frames_sent = 0x0000.

Source files
------------

// File: rtl/sort8_frame_loader.sv
// Packs a valid/ready byte stream into 8-slot frames, pads short frames,
// and holds each frame on a1..h1 until the downstream sorter accepts it.
module sort8_frame_loader #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   PAD_VALUE = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] e1,
    output logic [WIDTH-1:0] f1,
    output logic [WIDTH-1:0] g1,
    output logic [WIDTH-1:0] h1,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [3:0]       frame_count,
    output logic [15:0]      frames_sent
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]  state_reg, state_next;
    logic [2:0]  index_reg, index_next;
    logic        frame_valid_reg, frame_valid_next;
    logic [3:0]  frame_count_reg, frame_count_next;
    logic [15:0] frames_sent_reg, frames_sent_next;

    logic xfer;
    logic close;
    logic rel;

    logic [7:0][WIDTH-1:0] slots;

    assign s_ready = (state_reg == FILL);
    assign xfer    = s_valid && s_ready;
    assign close   = xfer && ((index_reg == 3'd7) || s_last);
    assign rel     = frame_valid_reg && frame_ready;

    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        frame_valid_next = frame_valid_reg;
        frame_count_next = frame_count_reg;
        frames_sent_next = frames_sent_reg;
        case (state_reg)
            FILL: begin
                if (close) begin
                    state_next       = HOLD;
                    index_next       = 3'd0;
                    frame_valid_next = 1'b1;
                    frame_count_next = {1'b0, index_reg} + 4'd1;
                end else if (xfer) begin
                    index_next = index_reg + 3'd1;
                end
            end
            default: begin
                if (rel) begin
                    state_next       = FILL;
                    frame_valid_next = 1'b0;
                    frames_sent_next = frames_sent_reg + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FILL;
            index_reg       <= 3'd0;
            frame_valid_reg <= 1'b0;
            frame_count_reg <= 4'd0;
            frames_sent_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            frame_valid_reg <= frame_valid_next;
            frame_count_reg <= frame_count_next;
            frames_sent_reg <= frames_sent_next;
        end
    end

    // Each slot takes the byte aimed at it, or the pad when the frame closes below it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_slot
            localparam logic [2:0] SLOT = 3'(gi);
            logic [WIDTH-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (xfer) begin
                    if (index_reg == SLOT) begin
                        slot_reg <= s_data;
                    end else if (close && (index_reg < SLOT)) begin
                        slot_reg <= PAD_VALUE;
                    end
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    assign a1 = slots[0];
    assign b1 = slots[1];
    assign c1 = slots[2];
    assign d1 = slots[3];
    assign e1 = slots[4];
    assign f1 = slots[5];
    assign g1 = slots[6];
    assign h1 = slots[7];

    assign frame_valid = frame_valid_reg;
    assign frame_count = frame_count_reg;
    assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_sort8_frame_loader.sv
// Directed checks for sort8_frame_loader: full, short, held, streamed,
// reset-interrupted and counter-wrap frames.
module tb_sort8_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [7:0]  a1, b1, c1, d1, e1, f1, g1, h1;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  frame_count;
    logic [15:0] frames_sent;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sort8_frame_loader #(.WIDTH(8), .PAD_VALUE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .a1(a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1), .h1(h1),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_count(frame_count), .frames_sent(frames_sent)
    );

    function automatic logic [63:0] frame_now();
        return {a1, b1, c1, d1, e1, f1, g1, h1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; all sampling/driving happens here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        $display("frame released, frames_sent=%0d", frames_sent);
    endtask

    logic [63:0] exp_frame;
    logic [63:0] held;
    int          nb, fidx, last_cyc;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; frame_ready = 1'b0;
        step();
        step();
        chk("rst_slots", frame_now(), 64'h0);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_count", frame_count, 4'd0);
        chk("rst_sent", frames_sent, 16'd0);
        chk("rst_ready", s_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Full frame 0x10..0x80 with s_valid held high
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'((i + 1) * 16);
            step();
            if (i == 6) chk("full_not_yet", frame_valid, 1'b0);
        end
        s_valid = 1'b0;
        chk("full_ready_drop", s_ready, 1'b0);
        chk("full_valid", frame_valid, 1'b1);
        chk("full_slots", frame_now(), 64'h1020304050607080);
        chk("full_count", frame_count, 4'd8);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_hold", {frame_now(), 3'b0, frame_valid, frame_count} , {64'h1020304050607080, 4'b0001, 4'd8});
        end
        release_frame();
        chk("full_rel_valid", frame_valid, 1'b0);
        chk("full_rel_sent", frames_sent, 16'd1);
        chk("full_rel_ready", s_ready, 1'b1);

        // Short frame padded with 0xFF
        send(8'h05, 1'b0);
        send(8'h03, 1'b0);
        send(8'h09, 1'b1);
        chk("short_valid", frame_valid, 1'b1);
        chk("short_slots", frame_now(), 64'h050309FFFFFFFFFF);
        chk("short_count", frame_count, 4'd3);

        // Byte offered during HOLD must wait for release
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_no_xfer", {s_ready, frame_now()}, {1'b0, 64'h050309FFFFFFFFFF});
        end
        release_frame();
        chk("hold_rel_sent", frames_sent, 16'd2);
        s_valid = 1'b1;
        step();
        chk("hold_aa_a1", a1, 8'hAA);
        send(8'h01, 1'b1);
        chk("aa_frame", {frame_now(), frame_count}, {64'hAA01FFFFFFFFFFFF, 4'd2});
        release_frame();
        chk("aa_rel_sent", frames_sent, 16'd3);

        // Three back-to-back full frames with frame_ready tied high
        frame_ready = 1'b1;
        nb = 0; fidx = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (frame_valid) begin
                exp_frame = '0;
                for (int j = 0; j < 8; j++) exp_frame[63 - 8*j -: 8] = 8'(8'h31 + 8*fidx + j);
                chk("stream_frame", frame_now(), exp_frame);
                if (last_cyc >= 0) chk("stream_period", 32'(cyc - last_cyc), 32'd9);
                $display("stream frame %0d at cycle %0d: %h", fidx, cyc, frame_now());
                last_cyc = cyc;
                fidx++;
            end
            if (s_ready && nb < 24) begin
                s_valid = 1'b1;
                s_data  = 8'(8'h31 + nb);
                nb++;
            end else if (s_ready) begin
                s_valid = 1'b0;
            end
            step();
        end
        s_valid = 1'b0;
        frame_ready = 1'b0;
        chk("stream_frames", 32'(fidx), 32'd3);
        chk("stream_bytes", 32'(nb), 32'd24);
        chk("stream_sent", frames_sent, 16'd6);

        // Asynchronous reset in the middle of a frame
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send(8'h44, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_slots", frame_now(), 64'h0);
        chk("arst_valid", frame_valid, 1'b0);
        chk("arst_sent", frames_sent, 16'd0);
        step();
        rst_n = 1'b1;
        chk("arst_ready", s_ready, 1'b1);
        send(8'h5A, 1'b1);
        chk("arst_next", {frame_now(), frame_valid, frame_count}, {64'h5AFFFFFFFFFFFFFF, 1'b1, 4'd1});
        release_frame();
        chk("arst_rel_sent", frames_sent, 16'd1);

        // frames_sent wrap from 0xFFFF
        force dut.frames_sent_reg = 16'hFFFF;
        #1;
        release dut.frames_sent_reg;
        #1;
        chk("wrap_preload", frames_sent, 16'hFFFF);
        send(8'h77, 1'b1);
        held = frame_now();
        chk("wrap_frame", held, 64'h77FFFFFFFFFFFFFF);
        release_frame();
        chk("wrap_sent", frames_sent, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
